osd_glyph_fetch_ctrl: RTL and testbench

- Sequencer for the OSD glyph ROM (descriptor ROM plus pattern ROM).
- Accepts one character code per handshake and computes the descriptor address.
- Latches the five descriptor fields (x, y, width, length, page), then walks the glyph rectangle row-major through the pattern ROM.
- Streams one pixel per cycle downstream with valid/ready backpressure. Sits between the text/layout engine and the pixel compositor.

---
 rtl/osd_glyph_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_osd_glyph_fetch_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_glyph_fetch_ctrl.sv
// OSD glyph fetch controller.
// Takes one character code, reads its five-field descriptor (x, y, width,
// length, page) from the descriptor ROM, then walks the glyph rectangle
// row-major through the pattern ROM, emitting one registered pixel per cycle
// under valid/ready backpressure.
// Optional feature macro: OSD_PIX_COORD_EN adds pix_col/pix_row outputs that
// carry the glyph-relative coordinate of each emitted pixel.
module osd_glyph_fetch_ctrl #(
  parameter int PAGES         = 2,
  parameter int PNG_W         = 64,
  parameter int PNG_H         = 64,
  parameter int MSB_BPP       = 8,
  parameter int LAST_CHAR     = 383,
  parameter int CHAR_ENCODING = 12,
  localparam int DA_W = $clog2((LAST_CHAR-31)*6),
  localparam int PA_W = $clog2(PAGES*PNG_W*PNG_H)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       char_valid,
  input  logic [CHAR_ENCODING-1:0]   char_code,
  output logic                       char_ready,
  output logic [DA_W-1:0]            data_addr,
  input  logic [5*CHAR_ENCODING-1:0] data_in,
  output logic [PA_W-1:0]            pattern_addr,
  input  logic [MSB_BPP-1:0]         pattern_in,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [MSB_BPP-1:0]         pix_data,
  output logic                       pix_eol,
  output logic                       pix_last,
  output logic                       busy,
  output logic                       err
`ifdef OSD_PIX_COORD_EN
  ,
  output logic [$clog2(PNG_W)-1:0]   pix_col,
  output logic [$clog2(PNG_H)-1:0]   pix_row
`endif
);

  localparam int CE  = CHAR_ENCODING;
  localparam int CE1 = CHAR_ENCODING + 1;

  // Code range and rectangle limits, pre-sized so every compare is same-width.
  localparam logic [CE-1:0]   CODE_MIN   = CE'(32);
  localparam logic [CE-1:0]   CODE_MAX   = CE'(LAST_CHAR);
  localparam logic [CE-1:0]   PG_LIM     = CE'(PAGES);
  localparam logic [CE:0]     W_LIM      = CE1'(PNG_W);
  localparam logic [CE:0]     H_LIM      = CE1'(PNG_H);
  localparam logic [DA_W-1:0] DESC_WORDS = DA_W'(6);
  localparam logic [PA_W-1:0] PG_SZ      = PA_W'(PNG_W*PNG_H);
  localparam logic [PA_W-1:0] ROW_SZ     = PA_W'(PNG_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DESC,
    S_CHECK,
    S_SCAN,
    S_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [DA_W-1:0]     data_addr_q, data_addr_d;
  logic [PA_W-1:0]     pattern_addr_q, pattern_addr_d;
  logic [CE-1:0]       x_q, x_d, y_q, y_d, w_q, w_d, l_q, l_d, pg_q, pg_d;
  logic [CE-1:0]       col_q, col_d, row_q, row_d;
  logic                pix_valid_q, pix_valid_d;
  logic [MSB_BPP-1:0]  pix_data_q, pix_data_d;
  logic                pix_eol_q, pix_eol_d;
  logic                pix_last_q, pix_last_d;
  logic                err_q, err_d;
`ifdef OSD_PIX_COORD_EN
  logic [$clog2(PNG_W)-1:0] pix_col_q, pix_col_d;
  logic [$clog2(PNG_H)-1:0] pix_row_q, pix_row_d;
`endif

  logic            load;
  logic            code_bad;
  logic            desc_bad;
  logic            desc_empty;
  logic            col_end;
  logic            row_end;
  logic [CE-1:0]   col_nx, row_nx;
  logic [CE:0]     x_end, y_end;

  // Linear pattern ROM address of (page, row, col); wraps at the ROM width.
  function automatic logic [PA_W-1:0] pix_addr(input logic [CE-1:0]   pg,
                                               input logic [PA_W-1:0] r,
                                               input logic [PA_W-1:0] c);
    return PA_W'(pg) * PG_SZ + r * ROW_SZ + c;
  endfunction

  // The output register may take a new pixel when empty or being drained.
  assign load     = !pix_valid_q || pix_ready;
  assign code_bad = (char_code < CODE_MIN) || (char_code > CODE_MAX);

  // Rectangle end points computed one bit wider so x+width cannot wrap.
  assign x_end      = {1'b0, x_q} + {1'b0, w_q};
  assign y_end      = {1'b0, y_q} + {1'b0, l_q};
  assign desc_bad   = (pg_q >= PG_LIM) || (x_end > W_LIM) || (y_end > H_LIM);
  assign desc_empty = (w_q == '0) || (l_q == '0);

  assign col_end = (col_q == w_q - CE'(1));
  assign row_end = (row_q == l_q - CE'(1));
  assign col_nx  = col_end ? '0 : col_q + CE'(1);
  assign row_nx  = col_end ? row_q + CE'(1) : row_q;

  // Next-state and datapath decode; everything holds unless a state acts on it.
  always_comb begin
    state_d        = state_q;
    data_addr_d    = data_addr_q;
    pattern_addr_d = pattern_addr_q;
    x_d            = x_q;
    y_d            = y_q;
    w_d            = w_q;
    l_d            = l_q;
    pg_d           = pg_q;
    col_d          = col_q;
    row_d          = row_q;
    pix_valid_d    = pix_valid_q;
    pix_data_d     = pix_data_q;
    pix_eol_d      = pix_eol_q;
    pix_last_d     = pix_last_q;
    err_d          = 1'b0;
`ifdef OSD_PIX_COORD_EN
    pix_col_d      = pix_col_q;
    pix_row_d      = pix_row_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (char_valid) begin
          if (code_bad) begin
            err_d = 1'b1;
          end else begin
            data_addr_d = DA_W'(char_code - CODE_MIN) * DESC_WORDS;
            state_d     = S_DESC;
          end
        end
      end
      S_DESC: begin
        x_d     = data_in[5*CE-1 -: CE];
        y_d     = data_in[4*CE-1 -: CE];
        w_d     = data_in[3*CE-1 -: CE];
        l_d     = data_in[2*CE-1 -: CE];
        pg_d    = data_in[CE-1:0];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (desc_bad) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (desc_empty) begin
          state_d = S_IDLE;
        end else begin
          col_d          = '0;
          row_d          = '0;
          pattern_addr_d = pix_addr(pg_q, PA_W'(y_q), PA_W'(x_q));
          state_d        = S_SCAN;
        end
      end
      S_SCAN: begin
        if (load) begin
          pix_data_d     = pattern_in;
          pix_valid_d    = 1'b1;
          pix_eol_d      = col_end;
          pix_last_d     = col_end && row_end;
`ifdef OSD_PIX_COORD_EN
          pix_col_d      = $clog2(PNG_W)'(col_q);
          pix_row_d      = $clog2(PNG_H)'(row_q);
`endif
          col_d          = col_nx;
          row_d          = row_nx;
          pattern_addr_d = pix_addr(pg_q, PA_W'(y_q) + PA_W'(row_nx),
                                    PA_W'(x_q) + PA_W'(col_nx));
          if (col_end && row_end) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pix_valid_q && pix_ready) begin
          pix_valid_d = 1'b0;
          pix_eol_d   = 1'b0;
          pix_last_d  = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      data_addr_q    <= '0;
      pattern_addr_q <= '0;
      x_q            <= '0;
      y_q            <= '0;
      w_q            <= '0;
      l_q            <= '0;
      pg_q           <= '0;
      col_q          <= '0;
      row_q          <= '0;
      pix_valid_q    <= 1'b0;
      pix_data_q     <= '0;
      pix_eol_q      <= 1'b0;
      pix_last_q     <= 1'b0;
      err_q          <= 1'b0;
`ifdef OSD_PIX_COORD_EN
      pix_col_q      <= '0;
      pix_row_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      data_addr_q    <= data_addr_d;
      pattern_addr_q <= pattern_addr_d;
      x_q            <= x_d;
      y_q            <= y_d;
      w_q            <= w_d;
      l_q            <= l_d;
      pg_q           <= pg_d;
      col_q          <= col_d;
      row_q          <= row_d;
      pix_valid_q    <= pix_valid_d;
      pix_data_q     <= pix_data_d;
      pix_eol_q      <= pix_eol_d;
      pix_last_q     <= pix_last_d;
      err_q          <= err_d;
`ifdef OSD_PIX_COORD_EN
      pix_col_q      <= pix_col_d;
      pix_row_q      <= pix_row_d;
`endif
    end
  end

  assign char_ready   = (state_q == S_IDLE);
  assign data_addr    = data_addr_q;
  assign pattern_addr = pattern_addr_q;
  assign pix_valid    = pix_valid_q;
  assign pix_data     = pix_data_q;
  assign pix_eol      = pix_eol_q;
  assign pix_last     = pix_last_q;
  assign err          = err_q;
  assign busy         = (state_q != S_IDLE) || pix_valid_q;
`ifdef OSD_PIX_COORD_EN
  assign pix_col      = pix_col_q;
  assign pix_row      = pix_row_q;
`endif

endmodule

// File: tb/tb_osd_glyph_fetch_ctrl.sv
// Scoreboard bench for osd_glyph_fetch_ctrl: stimulus pushes hand-computed
// pixels into a queue, a negedge monitor pops and compares on each transfer.
module tb_osd_glyph_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        char_valid;
  logic [11:0] char_code;
  logic        char_ready;
  logic [11:0] data_addr;
  logic [59:0] data_in;
  logic [12:0] pattern_addr;
  logic [7:0]  pattern_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        pix_eol;
  logic        pix_last;
  logic        busy;
  logic        err;
`ifdef OSD_PIX_COORD_EN
  logic [5:0]  pix_col;
  logic [5:0]  pix_row;
`endif

  always #5 clk = ~clk;

  osd_glyph_fetch_ctrl dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_code(char_code),
    .char_ready(char_ready), .data_addr(data_addr), .data_in(data_in),
    .pattern_addr(pattern_addr), .pattern_in(pattern_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_eol(pix_eol), .pix_last(pix_last), .busy(busy), .err(err)
`ifdef OSD_PIX_COORD_EN
    , .pix_col(pix_col), .pix_row(pix_row)
`endif
  );

  // Pattern ROM content: mixes high address bits so a page/row slip shows.
  function automatic logic [7:0] pat(input logic [12:0] a);
    return a[7:0] ^ {a[12:8], 3'b000};
  endfunction

  logic [59:0] drom [0:4095];
  assign data_in    = drom[data_addr];
  assign pattern_in = pat(pattern_addr);

  typedef struct packed {
    logic [7:0] d;
    logic       eol;
    logic       last;
    logic [5:0] col;
    logic [5:0] row;
  } px_t;
  px_t sb[$];

  int checks = 0, errors = 0;
  int cyc = 0, acc_edge = 0, xfer_edge = 0, pix_cnt = 0, err_cnt = 0, pv_cnt = 0;
  int rdy_mode = 0;
  bit lat_arm = 0, held = 0, prev_err = 0;
  logic [7:0] hold_d;
  logic hold_eol, hold_last;
  px_t e;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int a, input bit eol, input bit last, input int c, input int r);
    px_t p;
    p.d = pat(13'(a)); p.eol = eol; p.last = last; p.col = 6'(c); p.row = 6'(r);
    sb.push_back(p);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Backpressure driver: mode 0 always ready, mode 1 repeats 1,0,0,1.
  initial begin
    int ph;
    ph = 0;
    pix_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) pix_ready = 1'b1;
      else begin
        pix_ready = (ph == 0 || ph == 3);
        ph = (ph + 1) % 4;
      end
    end
  end

  // Monitor: latency, err pulse width, stall stability, scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      held = 0; lat_arm = 0; prev_err = 0;
    end else begin
      if (char_valid && char_ready) begin
        acc_edge = cyc + 1;
        lat_arm  = 1;
      end
      if (pix_valid) pv_cnt++;
      if (pix_valid && lat_arm) begin
        chk("first_pix_latency", cyc - acc_edge, 3);
        lat_arm = 0;
      end
      if (err) begin
        err_cnt++;
        chk("err_one_cycle", prev_err, 0);
      end
      prev_err = err;
      if (held) begin
        chk("stall_valid", pix_valid, 1);
        chk("stall_data", pix_data, hold_d);
        chk("stall_flags", {pix_eol, pix_last}, {hold_eol, hold_last});
      end
      if (pix_valid && pix_ready) begin
        pix_cnt++;
        xfer_edge = cyc + 1;
        if (sb.size() == 0) chk("unexpected_pixel", pix_data, -1);
        else begin
          e = sb.pop_front();
          chk("pix_data", pix_data, e.d);
          chk("pix_eol", pix_eol, e.eol);
          chk("pix_last", pix_last, e.last);
`ifdef OSD_PIX_COORD_EN
          chk("pix_col", pix_col, e.col);
          chk("pix_row", pix_row, e.row);
`endif
        end
      end
      held = pix_valid && !pix_ready;
      hold_d = pix_data; hold_eol = pix_eol; hold_last = pix_last;
    end
  end

  // Present a code; returns 1ns after the accepting edge.
  task automatic send(input int code, input bit hold);
    int n;
    @(posedge clk); #1;
    char_code = 12'(code); char_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!char_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("accept_timeout", n, 0);
    @(posedge clk); #1;
    if (!hold) char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); #1; n++; end while ((busy || sb.size() != 0) && n < 300);
    if (n >= 300) chk("idle_timeout", n, 0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic push_g65();
    push(5128, 0, 0, 0, 0); push(5129, 0, 0, 1, 0); push(5130, 1, 0, 2, 0);
    push(5192, 0, 0, 0, 1); push(5193, 0, 0, 1, 1); push(5194, 1, 1, 2, 1);
  endtask

  initial begin
    int c0, e0, p0, v0, n, b2b_xfer;
    logic [11:0] da0;
    rst = 1'b1; char_valid = 1'b0; char_code = '0;
    for (int i = 0; i < 4096; i++) drom[i] = '0;
    drom[198]  = {12'd8,  12'd16, 12'd3, 12'd2, 12'd1}; // code 65
    drom[204]  = {12'd62, 12'd0,  12'd3, 12'd1, 12'd0}; // code 66 x overflow
    drom[210]  = {12'd0,  12'd0,  12'd1, 12'd1, 12'd2}; // code 67 bad page
    drom[216]  = {12'd0,  12'd0,  12'd0, 12'd1, 12'd0}; // code 68 width 0
    drom[222]  = {12'd5,  12'd7,  12'd1, 12'd1, 12'd0}; // code 69 1x1
    drom[228]  = {12'd63, 12'd63, 12'd1, 12'd1, 12'd1}; // code 70 1x1 corner
    drom[2106] = {12'd62, 12'd0,  12'd2, 12'd1, 12'd0}; // code 383 right edge

    repeat (2) @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_char_ready", char_ready, 1);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_flags", {pix_eol, pix_last, err, busy}, 0);
    chk("rst_data_addr", data_addr, 0);
    chk("rst_pattern_addr", pattern_addr, 0);

    // Basic 3x2 glyph at full throughput.
    c0 = pix_cnt; push_g65();
    send(65, 0);
    chk("data_addr_65", data_addr, 198);
    wait_idle();
    chk("g65_pixels", pix_cnt - c0, 6);

    // Same glyph under 1,0,0,1 backpressure.
    rdy_mode = 1; c0 = pix_cnt; push_g65();
    send(65, 0);
    wait_idle();
    rdy_mode = 0;
    chk("stall_pixels", pix_cnt - c0, 6);

    // Out-of-range codes.
    da0 = data_addr; e0 = err_cnt; v0 = pv_cnt;
    send(31, 0);
    chk("err_now_31", err, 1);
    repeat (3) @(negedge clk); #1;
    chk("err_cnt_31", err_cnt - e0, 1);
    send(384, 0);
    repeat (3) @(negedge clk); #1;
    chk("err_cnt_384", err_cnt - e0, 2);
    chk("daddr_hold", data_addr, da0);
    chk("ready_after_err", char_ready, 1);
    chk("no_pv_bad_code", pv_cnt - v0, 0);

    // Rejected / empty descriptors.
    e0 = err_cnt; v0 = pv_cnt;
    send(66, 0); wait_idle();
    chk("err_x_overflow", err_cnt - e0, 1);
    send(67, 0); wait_idle();
    chk("err_bad_page", err_cnt - e0, 2);
    send(68, 0); wait_idle();
    chk("no_err_width0", err_cnt - e0, 2);
    chk("no_pv_rejects", pv_cnt - v0, 0);

    // Highest code, glyph touching the right page edge.
    c0 = pix_cnt;
    push(62, 0, 0, 0, 0); push(63, 1, 1, 1, 0);
    send(383, 0);
    chk("data_addr_383", data_addr, 2106);
    wait_idle();
    chk("g383_pixels", pix_cnt - c0, 2);

    // Reset after the 2nd pixel of a 3x2 glyph.
    c0 = pix_cnt; push_g65();
    send(65, 0);
    n = 0;
    while (pix_cnt < c0 + 2 && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) chk("rst_wait_timeout", n, 0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("mid_rst_pix_valid", pix_valid, 0);
    chk("mid_rst_outputs", {pix_data, pix_eol, pix_last, err, busy}, 0);
    chk("mid_rst_addrs", {data_addr, pattern_addr}, 0);
    chk("mid_rst_ready", char_ready, 1);
    chk("mid_rst_left", sb.size(), 4);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    c0 = pix_cnt; push_g65();
    send(65, 0);
    wait_idle();
    chk("post_rst_pixels", pix_cnt - c0, 6);

    // Back-to-back 1x1 glyphs with char_valid held.
    c0 = pix_cnt;
    push(453, 1, 1, 0, 0); push(8191, 1, 1, 0, 0);
    send(69, 1);
    char_code = 12'd70;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!(char_valid && char_ready) && n < 100);
    b2b_xfer = xfer_edge;
    @(posedge clk); #1 char_valid = 1'b0;
    chk("b2b_accept_edge", acc_edge - b2b_xfer, 1);
    wait_idle();
    chk("b2b_pixels", pix_cnt - c0, 2);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
